// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the write-back path.
package rf_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] RF_ZERO_IDX = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo N; returns the grant one-hot and encoded.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic found;
  int   j;

  // NOTE: every output of this always_comb gets a default before the loop, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = j[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for NUM_REQ write-back sources.
// Optional read bypass to the RF read ports when RF_WB_BYPASS_EN is defined.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*REG_IDX_W-1:0] req_index,
  input  logic [NUM_REQ*XLEN-1:0]      req_data,
  input  logic                         wb_hold,
  output logic                         enable_write,
  output logic [REG_IDX_W-1:0]         index_write,
  output logic [XLEN-1:0]              write_data,
  output logic [CNT_W-1:0]             contention_cnt
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [REG_IDX_W-1:0]         index_a,
  input  logic [REG_IDX_W-1:0]         index_b,
  input  logic [XLEN-1:0]              rf_output_a,
  input  logic [XLEN-1:0]              rf_output_b,
  output logic [XLEN-1:0]              fwd_a,
  output logic [XLEN-1:0]              fwd_b
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   arb_req;
  logic                 any_grant;
  logic                 multi_valid;
  logic [REG_IDX_W-1:0] sel_idx;
  logic [XLEN-1:0]      sel_data;
  rf_wr_t               wr_q;
  logic                 wr_en_q;
  logic [CNT_W-1:0]     cnt_q;

  // Hold and reset both suppress grants so ready is never seen while stalled.
  assign arb_req = req_valid & {NUM_REQ{~wb_hold & ~reset}};

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready   = grant;
  assign any_grant   = |grant;
  assign sel_idx     = req_index[grant_idx*REG_IDX_W +: REG_IDX_W];
  assign sel_data    = req_data[grant_idx*XLEN +: XLEN];
  assign multi_valid = $countones(req_valid) >= 2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // NOTE: the write-data register is reset as well, because its reset value
  // is visible on the RF port and a pending write must be dropped on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      wr_en_q <= 1'b0;
    end else if (any_grant) begin
      wr_q    <= '{idx: sel_idx, data: sel_data};
      wr_en_q <= (sel_idx != RF_ZERO_IDX);
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (multi_valid && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign enable_write   = wr_en_q;
  assign index_write    = wr_q.idx;
  assign write_data     = wr_q.data;
  assign contention_cnt = cnt_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the in-flight write to readers of the same register (never x0).
  assign fwd_a = (wr_en_q && (wr_q.idx == index_a) && (index_a != RF_ZERO_IDX))
                 ? wr_q.data : rf_output_a;
  assign fwd_b = (wr_en_q && (wr_q.idx == index_b) && (index_b != RF_ZERO_IDX))
                 ? wr_q.data : rf_output_b;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of arbitration and write-back.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int N       = 3;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*5-1:0]   req_index;
  logic [N*32-1:0]  req_data;
  logic             wb_hold;
  logic             enable_write;
  logic [4:0]       index_write;
  logic [31:0]      write_data;
  logic [CW-1:0]    contention_cnt;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]       index_a, index_b;
  logic [31:0]      rf_output_a, rf_output_b, fwd_a, fwd_b;
`endif

  rf_wb_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_index      (req_index),
    .req_data       (req_data),
    .wb_hold        (wb_hold),
    .enable_write   (enable_write),
    .index_write    (index_write),
    .write_data     (write_data),
    .contention_cnt (contention_cnt)
`ifdef RF_WB_BYPASS_EN
    ,
    .index_a        (index_a),
    .index_b        (index_b),
    .rf_output_a    (rf_output_a),
    .rf_output_b    (rf_output_b),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Requester-side pending transactions.
  bit          pend   [N];
  logic [4:0]  p_idx  [N];
  logic [31:0] p_data [N];

  // Reference model state.
  int          m_rr;
  int          m_cnt;
  int          last_grant;
  bit          m_en;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic [31:0] rf [32];
  int          seq [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend[i];
      req_index[5*i +: 5] = p_idx[i];
      req_data[32*i +: 32] = p_data[i];
    end
  endtask

  function automatic int model_grant();
    if (wb_hold || reset) return -1;
    for (int k = 0; k < N; k++) begin
      if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step();
    int          g;
    int          nv;
    logic [N-1:0] exp_rdy;
    logic        cen;
    logic [4:0]  cidx;
    logic [31:0] cdat;
    drive();
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("enable_write", 32'(enable_write), 32'(m_en));
    if (m_en) begin
      check("index_write", 32'(index_write), 32'(m_idx));
      check("write_data", write_data, m_data);
    end
    check("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
`ifdef RF_WB_BYPASS_EN
    check("fwd_a", fwd_a, (m_en && m_idx == index_a && index_a != 0) ? m_data : rf_output_a);
    check("fwd_b", fwd_b, (m_en && m_idx == index_b && index_b != 0) ? m_data : rf_output_b);
`endif
    cen  = enable_write;
    cidx = index_write;
    cdat = write_data;
    @(posedge clock);
    if (cen && cidx != 5'd0) rf[cidx] = cdat;
    nv = 0;
    for (int i = 0; i < N; i++) nv += int'(pend[i]);
    if (nv >= 2 && m_cnt < CNT_MAX) m_cnt++;
    if (g >= 0) begin
      m_en       = (p_idx[g] != 5'd0);
      m_idx      = p_idx[g];
      m_data     = p_data[g];
      m_rr       = (g + 1) % N;
      pend[g]    = 1'b0;
      last_grant = g;
    end else begin
      m_en       = 1'b0;
      last_grant = -1;
    end
    @(negedge clock);
  endtask

  // Asserts reset for one cycle starting at a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_enable_write", 32'(enable_write), 32'd0);
    check("rst_index_write", 32'(index_write), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_cnt", 32'(contention_cnt), 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    m_rr   = 0;
    m_en   = 1'b0;
    m_cnt  = 0;
    m_idx  = '0;
    m_data = '0;
  endtask

  task automatic post(input int i, input logic [4:0] idx, input logic [31:0] data);
    pend[i]   = 1'b1;
    p_idx[i]  = idx;
    p_data[i] = data;
  endtask

  initial begin
    reset     = 1'b1;
    wb_hold   = 1'b0;
    req_valid = '0;
    req_index = '0;
    req_data  = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_idx[i] = '0; p_data[i] = '0;
    end
`ifdef RF_WB_BYPASS_EN
    index_a = '0; index_b = '0; rf_output_a = '0; rf_output_b = '0;
`endif
    repeat (2) @(negedge clock);
    do_reset();

    // Single request and RF commit
    post(0, 5'd5, 32'h1234_5678);
    step();
    step();
    check("rf5", rf[5], 32'h1234_5678);

    // Fairness under continuous contention
    do_reset();
    for (int c = 0; c < 4; c++) begin
      post(0, 5'd1, 32'h100 + 32'(c));
      post(1, 5'd2, 32'h200 + 32'(c));
      step();
      seq[c] = last_grant;
    end
    for (int c = 0; c < 4; c++) check("fair_seq", 32'(seq[c]), 32'(c % 2));
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    #1;
    check("fair_cnt", 32'(contention_cnt), 32'd4);
    step();

    // x0 write is accepted but never enabled
    do_reset();
    post(1, 5'd0, 32'd103);
    step();
    #1;
    check("x0_en", 32'(enable_write), 32'd0);
    step();
    check("rf0", rf[0], 32'd0);

    // Hold freezes grant and pointer; counter keeps counting and saturates
    do_reset();
    post(0, 5'd3, 32'hA0);
    post(1, 5'd4, 32'hB0);
    step();
    post(0, 5'd3, 32'hA1);
    wb_hold = 1'b1;
    repeat (3) step();
    wb_hold = 1'b0;
    step();
    check("hold_resume", 32'(last_grant), 32'd1);
    post(1, 5'd4, 32'hB1);
    wb_hold = 1'b1;
    repeat (20) step();
    #1;
    check("cnt_sat", 32'(contention_cnt), 32'(CNT_MAX));
    wb_hold = 1'b0;
    step();

    // Reset the cycle after acceptance drops the pending write
    do_reset();
    post(0, 5'd7, 32'hDEAD_BEEF);
    step();
    do_reset();
    step();
    check("rf7_dropped", rf[7], 32'd0);

`ifdef RF_WB_BYPASS_EN
    // Bypass of the in-flight write
    post(0, 5'd12, 32'd103);
    step();
    index_a     = 5'd12;
    rf_output_a = 32'h0BAD_0BAD;
    #1;
    check("bypass_fwd_a", fwd_a, 32'd103);
    step();
`endif

    // Randomized traffic with occasional hold and mid-run resets
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 2 == 0))
          post(i, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom), $urandom);
      end
      wb_hold = ($urandom % 5 == 0);
`ifdef RF_WB_BYPASS_EN
      index_a     = ($urandom % 2 == 0) ? m_idx : 5'($urandom);
      index_b     = ($urandom % 2 == 0) ? m_idx : 5'($urandom);
      rf_output_a = $urandom;
      rf_output_b = $urandom;
`endif
      if (cyc % 150 == 149) begin
        wb_hold = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
